eth_txarb_rr: RTL and testbench

- N-channel, packet-granular round-robin TX arbiter.
- Merges N per-source FWFT FIFOs (PCIe TLP taps, clk156 domain) into one tagged output stream toward the arb2encap FIFO.
- Successor to the fixed 2-channel arbiter, generalised in channel count and word width.
- Adds per-channel enable masking, an oversize-packet truncation guard and a one-cycle registered output stage.

---
 rtl/eth_txarb_rr.sv | 228 ++++++++++++++++++++++
 tb/tb_eth_txarb_rr.sv | 362 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/eth_txarb_rr.sv
`default_nettype none
// ============================================================================
//  Module      : eth_txarb_rr
//  Description : N-channel, packet-granular round-robin TX arbiter. Merges
//                N per-source FWFT FIFOs into one tagged output stream
//                ({channel tag, word}) toward the arb2encap FIFO. Provides
//                per-channel grant enables, an oversize-packet truncation
//                guard and a one-cycle registered output stage.
//  Revision    : 1.0  initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk156      in   1          single clock for the whole block
//    sys_rst     in   1          asynchronous, active-high reset
//    ch_en       in   N_CH       per-channel grant enable (gates new grants)
//    fifo_dout   in   N_CH*IN_W  FWFT head words, channel i at [i*IN_W +: IN_W]
//    fifo_empty  in   N_CH       per-channel FIFO empty
//    fifo_rd_en  out  N_CH       per-channel pop (combinational)
//    din         out  OUT_W      output word {tag, word} (registered)
//    wr_en       out  1          output write strobe (registered)
//    out_afull   in   1          output FIFO prog_full (free entries <= 2)
//    busy        out  1          high while the arbiter is not idle
//    trunc_err   out  N_CH       sticky per-channel truncation flag
// ============================================================================
module eth_txarb_rr #(
    parameter int N_CH      = 4,
    parameter int IN_W      = 81,
    parameter int LAST_BIT  = 80,
    parameter int CH_W      = (N_CH > 1) ? $clog2(N_CH) : 1,
    parameter int OUT_W     = IN_W + CH_W,
    parameter int MAX_BEATS = 512
) (
    input  logic                 clk156,
    input  logic                 sys_rst,
    input  logic [N_CH-1:0]      ch_en,
    input  logic [N_CH*IN_W-1:0] fifo_dout,
    input  logic [N_CH-1:0]      fifo_empty,
    output logic [N_CH-1:0]      fifo_rd_en,
    output logic [OUT_W-1:0]     din,
    output logic                 wr_en,
    input  logic                 out_afull,
    output logic                 busy,
    output logic [N_CH-1:0]      trunc_err
);

    // Beat counter only needs to reach MAX_BEATS-1 before the packet is
    // either finished or diverted into DROP.
    localparam int c_beat_w = $clog2(MAX_BEATS);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_XFER = 2'd1,
        S_DROP = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;

    logic [CH_W-1:0]       r_rr_ptr;
    logic [CH_W-1:0]       r_grant;
    logic [c_beat_w-1:0]   r_beat_cnt;
    logic                  r_wr_en;
    logic [OUT_W-1:0]      r_din;
    logic [N_CH-1:0]       r_trunc_err;

    logic [N_CH-1:0]       w_elig;
    logic                  w_any_elig;
    logic [CH_W-1:0]       w_pick;
    logic [CH_W:0]         w_sum;
    logic [CH_W-1:0]       w_cand;
    logic [CH_W-1:0]       w_grant_inc;
    logic [IN_W-1:0]       w_words [N_CH];
    logic [IN_W-1:0]       w_head;
    logic [IN_W-1:0]       w_word_out;
    logic                  w_pop;
    logic                  w_last;
    logic                  w_at_limit;
    logic                  w_trunc;

    // ------------------------------------------------------------------
    // Head-word selection
    // ------------------------------------------------------------------
    genvar g;
    generate
        for (g = 0; g < N_CH; g++) begin : g_unpack
            assign w_words[g] = fifo_dout[g*IN_W +: IN_W];
        end
    endgenerate

    assign w_head     = w_words[r_grant];
    assign w_last     = w_head[LAST_BIT];
    assign w_at_limit = (r_beat_cnt == c_beat_w'(MAX_BEATS - 1));

    // ------------------------------------------------------------------
    // Round-robin pick
    // ------------------------------------------------------------------
    assign w_elig     = ch_en & ~fifo_empty;
    assign w_any_elig = |w_elig;

    // Walk the scan order backwards so the last hit written is the one
    // closest to rr_ptr; avoids an early-exit loop.
    always_comb begin
        w_pick = r_rr_ptr;
        w_sum  = '0;
        w_cand = '0;
        for (int k = N_CH - 1; k >= 0; k--) begin
            w_sum = {1'b0, r_rr_ptr} + (CH_W+1)'(k);
            if (w_sum >= (CH_W+1)'(N_CH)) begin
                w_sum = w_sum - (CH_W+1)'(N_CH);
            end
            w_cand = w_sum[CH_W-1:0];
            if (w_elig[w_cand]) begin
                w_pick = w_cand;
            end
        end
    end

    // Channel after the current grant, wrapping for non-power-of-2 N_CH.
    assign w_grant_inc = (r_grant == CH_W'(N_CH - 1)) ? '0 : r_grant + CH_W'(1);

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk156 or posedge sys_rst) begin
        if (sys_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state and pop generation
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        fifo_rd_en  = '0;
        case (r_state)
            S_IDLE: begin
                // Grant is registered here; the first pop follows next cycle.
                if (w_any_elig) begin
                    w_state_nxt = S_XFER;
                end
            end
            S_XFER: begin
                w_pop = ~fifo_empty[r_grant] & ~out_afull;
                if (w_pop) begin
                    if (w_last) begin
                        w_state_nxt = S_IDLE;
                    end else if (w_at_limit) begin
                        w_state_nxt = S_DROP;
                    end
                end
            end
            S_DROP: begin
                // Discarded words never reach the output, so backpressure
                // does not apply while draining.
                w_pop = ~fifo_empty[r_grant];
                if (w_pop && w_last) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
        fifo_rd_en[r_grant] = w_pop;
    end

    // Truncation only when the limit beat is not already a tlast.
    assign w_trunc = (r_state == S_XFER) & w_pop & ~w_last & w_at_limit;

    always_comb begin
        w_word_out           = w_head;
        w_word_out[LAST_BIT] = w_head[LAST_BIT] | w_trunc;
    end

    // ------------------------------------------------------------------
    // Datapath: grant, pointer, beat counter, output register, errors
    // ------------------------------------------------------------------
    always_ff @(posedge clk156 or posedge sys_rst) begin
        if (sys_rst) begin
            r_rr_ptr    <= '0;
            r_grant     <= '0;
            r_beat_cnt  <= '0;
            r_wr_en     <= 1'b0;
            r_din       <= '0;
            r_trunc_err <= '0;
        end else begin
            r_wr_en <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_any_elig) begin
                        r_grant    <= w_pick;
                        r_beat_cnt <= '0;
                    end
                end
                S_XFER: begin
                    if (w_pop) begin
                        r_wr_en    <= 1'b1;
                        r_din      <= {r_grant, w_word_out};
                        r_beat_cnt <= r_beat_cnt + c_beat_w'(1);
                        if (w_last) begin
                            r_rr_ptr <= w_grant_inc;
                        end
                        if (w_trunc) begin
                            r_trunc_err[r_grant] <= 1'b1;
                        end
                    end
                end
                S_DROP: begin
                    if (w_pop && w_last) begin
                        r_rr_ptr <= w_grant_inc;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign din       = r_din;
    assign wr_en     = r_wr_en;
    assign trunc_err = r_trunc_err;
    assign busy      = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_eth_txarb_rr.sv
`default_nettype none
// ============================================================================
//  Module      : tb_eth_txarb_rr
//  Description : Self-checking bench for eth_txarb_rr. Models the upstream
//                FWFT FIFOs as queues, predicts every output word into a
//                scoreboard queue and compares on each wr_en.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_eth_txarb_rr;

    localparam int N_CH      = 4;
    localparam int IN_W      = 81;
    localparam int LAST_BIT  = 80;
    localparam int CH_W      = 2;
    localparam int OUT_W     = IN_W + CH_W;
    localparam int MAX_BEATS = 8;

    logic                 clk156 = 1'b0;
    logic                 sys_rst;
    logic [N_CH-1:0]      ch_en;
    logic [N_CH*IN_W-1:0] fifo_dout;
    logic [N_CH-1:0]      fifo_empty;
    logic [N_CH-1:0]      fifo_rd_en;
    logic [OUT_W-1:0]     din;
    logic                 wr_en;
    logic                 out_afull;
    logic                 busy;
    logic [N_CH-1:0]      trunc_err;

    eth_txarb_rr #(
        .N_CH      (N_CH),
        .IN_W      (IN_W),
        .LAST_BIT  (LAST_BIT),
        .CH_W      (CH_W),
        .OUT_W     (OUT_W),
        .MAX_BEATS (MAX_BEATS)
    ) dut (
        .clk156     (clk156),
        .sys_rst    (sys_rst),
        .ch_en      (ch_en),
        .fifo_dout  (fifo_dout),
        .fifo_empty (fifo_empty),
        .fifo_rd_en (fifo_rd_en),
        .din        (din),
        .wr_en      (wr_en),
        .out_afull  (out_afull),
        .busy       (busy),
        .trunc_err  (trunc_err)
    );

    always #5 clk156 = ~clk156;

    // Upstream FIFO contents and scoreboard
    logic [IN_W-1:0]  q [N_CH][$];
    logic [OUT_W-1:0] exp_q [$];
    logic [OUT_W-1:0] exp_w;
    int               pc [N_CH];
    int               ec [N_CH];

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    int wr_cnt   = 0;
    int first_wr = -1;
    int last_wr  = -1;
    logic [N_CH-1:0] rd_lat  = '0;
    logic [N_CH-1:0] rd_seen = '0;

    typedef struct {
        logic [3:0]      en;
        logic [3:0]      load;
        int              n;
        logic [3:0][1:0] tags;
    } vec_t;

    vec_t tv [7];

    function automatic vec_t mk_vec(logic [3:0] en, logic [3:0] load, int n,
                                    logic [1:0] t0, logic [1:0] t1,
                                    logic [1:0] t2, logic [1:0] t3);
        vec_t v;
        v.en      = en;
        v.load    = load;
        v.n       = n;
        v.tags[0] = t0;
        v.tags[1] = t1;
        v.tags[2] = t2;
        v.tags[3] = t3;
        return v;
    endfunction

    function automatic logic [IN_W-1:0] mkw(int ch, int pkt, int beat, bit last);
        logic [IN_W-1:0] w;
        w           = '0;
        w[15:0]     = 16'(beat);
        w[31:16]    = 16'(pkt);
        w[47:32]    = 16'(ch);
        w[79:48]    = 32'hC0DE_0000 ^ 32'(ch * 97 + pkt * 13 + beat);
        w[LAST_BIT] = last;
        return w;
    endfunction

    task automatic chk(string nm, logic [127:0] act, logic [127:0] req);
        n_checks++;
        if (act === req) begin
            n_pass++;
        end else begin
            $display("FAIL %s: actual=%0h required=%0h", nm, act, req);
        end
    endtask

    task automatic refresh();
        for (int i = 0; i < N_CH; i++) begin
            fifo_empty[i] = (q[i].size() == 0);
            fifo_dout[i*IN_W +: IN_W] = (q[i].size() > 0) ? q[i][0] : '0;
        end
    endtask

    task automatic push_pkt(int ch, int nb);
        for (int b = 0; b < nb; b++) begin
            q[ch].push_back(mkw(ch, pc[ch], b, (b == nb - 1)));
        end
        pc[ch]++;
        refresh();
    endtask

    // Predict the words a packet of nb beats produces, with truncation at lim.
    task automatic exp_pkt(int ch, int nb, int lim);
        logic [IN_W-1:0] w;
        int nw;
        nw = (nb > lim) ? lim : nb;
        for (int b = 0; b < nw; b++) begin
            w = mkw(ch, ec[ch], b, (b == nb - 1));
            if (nb > lim && b == lim - 1) begin
                w[LAST_BIT] = 1'b1;
            end
            exp_q.push_back({CH_W'(ch), w});
        end
        ec[ch]++;
    endtask

    task automatic tick();
        @(posedge clk156);
        #2;
    endtask

    task automatic wait_done(string nm, int budget);
        int k;
        k = 0;
        while ((exp_q.size() != 0 || busy) && k < budget) begin
            tick();
            k++;
        end
        chk({nm, "_done"}, 32'(k < budget), 1);
    endtask

    task automatic wait_writes(string nm, int target, int budget);
        int k;
        k = 0;
        while (wr_cnt < target && k < budget) begin
            tick();
            k++;
        end
        chk({nm, "_writes"}, 32'(k < budget), 1);
    endtask

    // Output monitor / scoreboard, sampled mid-cycle
    always @(negedge clk156) begin
        cyc++;
        rd_lat  = fifo_rd_en;
        rd_seen = rd_seen | fifo_rd_en;
        if (!sys_rst && wr_en) begin
            wr_cnt++;
            if (first_wr < 0) first_wr = cyc;
            last_wr = cyc;
            if (exp_q.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_write: actual din=%0h required no write", din);
            end else begin
                exp_w = exp_q.pop_front();
                chk("sb_din", din, exp_w);
            end
        end
    end

    // Upstream FIFO model: apply the pops the DUT issued in the last cycle
    always @(posedge clk156) begin
        #1;
        for (int i = 0; i < N_CH; i++) begin
            if (rd_lat[i]) begin
                chk("pop_nonempty", 32'(q[i].size() > 0), 1);
                if (q[i].size() > 0) void'(q[i].pop_front());
            end
        end
        refresh();
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int w0;

        tv[0] = mk_vec(4'hF,    4'b0100, 1, 2'd2, 2'd0, 2'd0, 2'd0);
        tv[1] = mk_vec(4'hF,    4'b0011, 2, 2'd0, 2'd1, 2'd0, 2'd0);
        tv[2] = mk_vec(4'b0101, 4'b1111, 2, 2'd2, 2'd0, 2'd0, 2'd0);
        tv[3] = mk_vec(4'hF,    4'b0000, 2, 2'd1, 2'd3, 2'd0, 2'd0);
        tv[4] = mk_vec(4'b1000, 4'b1001, 1, 2'd3, 2'd0, 2'd0, 2'd0);
        tv[5] = mk_vec(4'hF,    4'b0110, 3, 2'd0, 2'd1, 2'd2, 2'd0);
        tv[6] = mk_vec(4'hF,    4'b1000, 1, 2'd3, 2'd0, 2'd0, 2'd0);

        for (int i = 0; i < N_CH; i++) begin
            pc[i] = 0;
            ec[i] = 0;
        end
        sys_rst   = 1'b1;
        ch_en     = 4'hF;
        out_afull = 1'b0;
        refresh();
        repeat (3) tick();

        // Reset state
        chk("rst_wr_en", wr_en, 0);
        chk("rst_din", din, 0);
        chk("rst_busy", busy, 0);
        chk("rst_trunc_err", trunc_err, 0);
        chk("rst_rd_en", fifo_rd_en, 0);
        sys_rst = 1'b0;
        tick();

        // Table-driven single-beat arbitration vectors
        for (int v = 0; v < 7; v++) begin
            ch_en = tv[v].en;
            base  = wr_cnt;
            for (int c = 0; c < N_CH; c++) begin
                if (tv[v].load[c]) push_pkt(c, 1);
            end
            for (int k = 0; k < tv[v].n; k++) begin
                exp_pkt(int'(tv[v].tags[k]), 1, MAX_BEATS);
            end
            wait_done($sformatf("vec%0d", v), 60);
            chk($sformatf("vec%0d_count", v), 32'(wr_cnt - base), 32'(tv[v].n));
        end

        // Round-robin over four 3-beat packets
        ch_en    = 4'hF;
        base     = wr_cnt;
        first_wr = -1;
        for (int c = 0; c < N_CH; c++) push_pkt(c, 3);
        for (int c = 0; c < N_CH; c++) exp_pkt(c, 3, MAX_BEATS);
        wait_done("rr", 100);
        chk("rr_count", 32'(wr_cnt - base), 12);
        chk("rr_span", 32'(last_wr - first_wr + 1), 15);

        // Fairness: ch0 three packets, ch2 one
        base = wr_cnt;
        for (int k = 0; k < 3; k++) push_pkt(0, 2);
        push_pkt(2, 2);
        exp_pkt(0, 2, MAX_BEATS);
        exp_pkt(2, 2, MAX_BEATS);
        exp_pkt(0, 2, MAX_BEATS);
        exp_pkt(0, 2, MAX_BEATS);
        wait_done("fair", 100);
        chk("fair_count", 32'(wr_cnt - base), 8);

        // Backpressure mid-packet on ch1
        base = wr_cnt;
        push_pkt(1, 6);
        exp_pkt(1, 6, MAX_BEATS);
        wait_writes("bp", base + 2, 40);
        out_afull = 1'b1;
        w0 = wr_cnt;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk156);
            #1;
            chk("bp_no_pop", fifo_rd_en, 0);
        end
        chk("bp_inflight_only", 32'(wr_cnt - w0), 1);
        tick();
        out_afull = 1'b0;
        wait_done("bp", 60);
        chk("bp_count", 32'(wr_cnt - base), 6);

        // Truncation: 12-beat packet on ch3, limit 8
        base = wr_cnt;
        push_pkt(3, 12);
        exp_pkt(3, 12, MAX_BEATS);
        wait_done("trunc", 100);
        chk("trunc_count", 32'(wr_cnt - base), 8);
        chk("trunc_err", trunc_err, 4'b1000);
        chk("trunc_drained", 32'(q[3].size()), 0);
        base = wr_cnt;
        push_pkt(0, 1);
        push_pkt(1, 1);
        push_pkt(3, 1);
        exp_pkt(0, 1, MAX_BEATS);
        exp_pkt(1, 1, MAX_BEATS);
        exp_pkt(3, 1, MAX_BEATS);
        wait_done("post_trunc", 60);
        chk("post_trunc_count", 32'(wr_cnt - base), 3);

        // Enable masking, ch_en[1] dropped mid-packet
        ch_en   = 4'b1010;
        rd_seen = '0;
        base    = wr_cnt;
        for (int c = 0; c < N_CH; c++) push_pkt(c, 3);
        exp_pkt(1, 3, MAX_BEATS);
        exp_pkt(3, 3, MAX_BEATS);
        wait_writes("mask", base + 1, 40);
        ch_en = 4'b1000;
        wait_done("mask", 60);
        chk("mask_count", 32'(wr_cnt - base), 6);
        chk("mask_no_pop_0_2", rd_seen & 4'b0101, 0);
        chk("mask_q0_left", 32'(q[0].size()), 3);
        chk("mask_q2_left", 32'(q[2].size()), 3);
        exp_pkt(0, 3, MAX_BEATS);
        exp_pkt(2, 3, MAX_BEATS);
        ch_en = 4'hF;
        wait_done("unmask", 60);

        // Asynchronous reset during XFER
        base = wr_cnt;
        push_pkt(1, 6);
        exp_pkt(1, 6, MAX_BEATS);
        wait_writes("arst", base + 2, 40);
        #1;
        chk("arst_pre_wr_en", wr_en, 1);
        sys_rst = 1'b1;
        #1;
        chk("arst_wr_en", wr_en, 0);
        chk("arst_busy", busy, 0);
        chk("arst_rd_en", fifo_rd_en, 0);
        chk("arst_din", din, 0);
        chk("arst_trunc_err", trunc_err, 0);
        for (int i = 0; i < N_CH; i++) begin
            q[i].delete();
            ec[i] = pc[i];
        end
        exp_q.delete();
        refresh();
        repeat (2) tick();
        sys_rst = 1'b0;
        tick();
        base = wr_cnt;
        push_pkt(3, 1);
        push_pkt(0, 1);
        exp_pkt(0, 1, MAX_BEATS);
        exp_pkt(3, 1, MAX_BEATS);
        wait_done("post_rst", 60);
        chk("post_rst_count", 32'(wr_cnt - base), 2);

        repeat (3) tick();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
